// File: rtl/shift_sequencer.sv
// Two-requester arbitrated 32-bit shifter (SLL/SRA) that resolves one shift stage per cycle.
// Optional macro SHIFT_ZERO_BYPASS_EN: a zero shift amount skips the stage sequence entirely.
module shift_sequencer #(
  parameter int PRIO_INIT = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [4:0]  req0_shamt,
  input  logic        req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [4:0]  req1_shamt,
  input  logic        req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_id,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

  localparam logic LP_PRIO = PRIO_INIT[0];

  state_t      r_state;
  state_t      w_nextState;
  logic        r_lastGrant;
  logic [31:0] r_work;
  logic [4:0]  r_shamt;
  logic        r_op;
  logic        r_sign;
  logic        r_id;
  logic [2:0]  r_stage;

  logic        w_grant;
  logic        w_accept;
  logic [31:0] w_aIn;
  logic [4:0]  w_shamtIn;
  logic        w_opIn;
  logic [4:0]  w_stageMask;
  logic        w_stageBit;
  logic [31:0] w_sll;
  logic [31:0] w_sra;

  // On a tie the requester that was not served last wins
  assign w_grant   = (req0_valid && req1_valid) ? ~r_lastGrant : req1_valid;
  assign w_aIn     = w_grant ? req1_a     : req0_a;
  assign w_shamtIn = w_grant ? req1_shamt : req0_shamt;
  assign w_opIn    = w_grant ? req1_op    : req0_op;

  assign w_stageMask = 5'd1 << r_stage;
  assign w_stageBit  = |(r_shamt & w_stageMask);
  assign w_sll       = r_work << w_stageMask;
  // Complementing around a logical shift fills the vacated bits with ones
  assign w_sra       = r_sign ? ~((~r_work) >> w_stageMask) : (r_work >> w_stageMask);

  assign rsp_valid = (r_state == RESP);
  assign busy      = (r_state != IDLE);
  assign rsp_data  = r_work;
  assign rsp_id    = r_id;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        if (reset_n && (req0_valid || req1_valid)) begin
          w_accept   = 1'b1;
          req0_ready = ~w_grant;
          req1_ready = w_grant;
`ifdef SHIFT_ZERO_BYPASS_EN
          w_nextState = (w_shamtIn == 5'd0) ? RESP : SHIFT;
`else
          w_nextState = SHIFT;
`endif
        end
      end
      SHIFT: begin
        if (r_stage == 3'd4) begin
          w_nextState = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lastGrant <= ~LP_PRIO;
      r_work      <= 32'd0;
      r_shamt     <= 5'd0;
      r_op        <= 1'b0;
      r_sign      <= 1'b0;
      r_id        <= 1'b0;
      r_stage     <= 3'd0;
    end else if (w_accept) begin
      r_lastGrant <= w_grant;
      r_work      <= w_aIn;
      r_shamt     <= w_shamtIn;
      r_op        <= w_opIn;
      r_sign      <= w_aIn[31];
      r_id        <= w_grant;
      r_stage     <= 3'd0;
    end else if (r_state == SHIFT) begin
      r_stage <= r_stage + 3'd1;
      if (w_stageBit) begin
        r_work <= r_op ? w_sra : w_sll;
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (PRIO_INIT = 0).
// Zero-shift latency expectation follows the SHIFT_ZERO_BYPASS_EN macro.
module tb_shift_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0_valid, req0_ready, req0_op;
  logic [31:0] req0_a;
  logic [4:0]  req0_shamt;
  logic        req1_valid, req1_ready, req1_op;
  logic [31:0] req1_a;
  logic [4:0]  req1_shamt;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_data;

  int checks = 0;
  int passes = 0;

`ifdef SHIFT_ZERO_BYPASS_EN
  localparam int LAT0 = 1;
`else
  localparam int LAT0 = 6;
`endif

  shift_sequencer #(.PRIO_INIT(0)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_shamt(req0_shamt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_shamt(req1_shamt), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
  endtask

  task automatic stepCycle;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic v0, input logic v1, input logic rr);
    req0_valid = v0;
    req1_valid = v1;
    rsp_ready  = rr;
    #1;
  endtask

  task automatic setReq(input logic id, input logic [31:0] a, input logic [4:0] sh, input logic op);
    if (id) begin
      req1_a = a; req1_shamt = sh; req1_op = op;
    end else begin
      req0_a = a; req0_shamt = sh; req0_op = op;
    end
  endtask

  // One request from a single requester; inputs are scrambled while it is in flight
  task automatic runOp(input logic id, input logic [31:0] a, input logic [4:0] sh, input logic op,
                       input logic [31:0] expData, input int expLat, input string tag);
    int lat;
    setReq(id, a, sh, op);
    applyStimulus(id == 1'b0, id == 1'b1, 1'b1);
    checkBit({tag, "_ready"}, id ? req1_ready : req0_ready, 1'b1);
    stepCycle;
    applyStimulus(1'b0, 1'b0, 1'b1);
    setReq(id, 32'hDEAD_BEEF, 5'd7, ~op);
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      stepCycle;
      lat++;
    end
    checkBit({tag, "_valid"}, rsp_valid, 1'b1);
    checkOutput({tag, "_lat"}, lat, expLat);
    checkOutput({tag, "_data"}, rsp_data, expData);
    checkBit({tag, "_id"}, rsp_id, id);
    stepCycle;
    checkBit({tag, "_done"}, rsp_valid, 1'b0);
  endtask

  initial begin
    int cnt;
    reset_n = 1'b0;
    setReq(1'b0, 32'h0, 5'd0, 1'b0);
    setReq(1'b1, 32'h0, 5'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkBit("rst_valid", rsp_valid, 1'b0);
    checkOutput("rst_data", rsp_data, 32'h0);
    checkBit("rst_id", rsp_id, 1'b0);
    checkBit("rst_busy", busy, 1'b0);
    checkBit("rst_ready0", req0_ready, 1'b0);
    checkBit("rst_ready1", req1_ready, 1'b0);
    stepCycle;
    stepCycle;
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);

    runOp(1'b0, 32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000, 6, "sll31");
    runOp(1'b0, 32'h0000_F000, 5'd12, 1'b1, 32'h0000_000F, 6, "sra12pos");
    runOp(1'b1, 32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000, 6, "sra4neg");
    runOp(1'b1, 32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000, 6, "sra31pos");
    runOp(1'b1, 32'hFFFF_FFFF, 5'd31, 1'b1, 32'hFFFF_FFFF, 6, "sra31neg");
    runOp(1'b1, 32'hFFFF_FFFF, 5'd16, 1'b0, 32'hFFFF_0000, 6, "sll16");
    runOp(1'b0, 32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, LAT0, "zero_sll");
    runOp(1'b1, 32'h8765_4321, 5'd0,  1'b1, 32'h8765_4321, LAT0, "zero_sra");

    // Fair alternation with both requesters permanently valid
    reset_n = 1'b0;
    stepCycle;
    reset_n = 1'b1;
    setReq(1'b0, 32'h0000_0003, 5'd1, 1'b0);
    setReq(1'b1, 32'h8000_0000, 5'd1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 4; n++) begin
      cnt = 0;
      while (!rsp_valid && cnt < 20) begin
        checkBit("arb_excl", req0_ready & req1_ready, 1'b0);
        stepCycle;
        cnt++;
      end
      checkBit("arb_valid", rsp_valid, 1'b1);
      checkBit("arb_id", rsp_id, n[0]);
      checkOutput("arb_data", rsp_data, n[0] ? 32'hC000_0000 : 32'h0000_0006);
      if (n == 3) applyStimulus(1'b0, 1'b0, 1'b1);
      stepCycle;
    end

    // Backpressure in RESP
    setReq(1'b0, 32'h0000_0F0F, 5'd4, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkBit("bp_accept", req0_ready, 1'b1);
    stepCycle;
    applyStimulus(1'b1, 1'b1, 1'b0);
    cnt = 0;
    while (!rsp_valid && cnt < 12) begin
      stepCycle;
      cnt++;
    end
    for (int i = 0; i < 10; i++) begin
      checkBit("bp_valid", rsp_valid, 1'b1);
      checkOutput("bp_data", rsp_data, 32'h0000_F0F0);
      checkBit("bp_id", rsp_id, 1'b0);
      checkBit("bp_noready", req0_ready | req1_ready, 1'b0);
      stepCycle;
    end
    setReq(1'b1, 32'hFFFF_FFF0, 5'd2, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkBit("bp_release_valid", rsp_valid, 1'b1);
    checkBit("bp_release_noaccept", req1_ready, 1'b0);
    stepCycle;
    checkBit("bp_idle_valid", rsp_valid, 1'b0);
    runOp(1'b1, 32'hFFFF_FFF0, 5'd2, 1'b1, 32'hFFFF_FFFC, 6, "after_bp");

    // Reset in the middle of a shift
    setReq(1'b1, 32'h0000_0005, 5'd3, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    stepCycle;
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepCycle;
    stepCycle;
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkBit("mid_rst_busy", busy, 1'b0);
    checkBit("mid_rst_valid", rsp_valid, 1'b0);
    checkOutput("mid_rst_data", rsp_data, 32'h0);
    checkBit("mid_rst_id", rsp_id, 1'b0);
    checkBit("mid_rst_ready1", req1_ready, 1'b0);
    stepCycle;
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      checkBit("mid_rst_noresp", rsp_valid, 1'b0);
      stepCycle;
    end
    setReq(1'b0, 32'h0000_00A5, 5'd8, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkBit("post_rst_tie0", req0_ready, 1'b1);
    checkBit("post_rst_tie1", req1_ready, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    runOp(1'b0, 32'h0000_00A5, 5'd8, 1'b0, 32'h0000_A500, 6, "post_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
